rx_queue_arbiter: RTL and testbench
===================================

Name: rx_queue_arbiter

Overview:
Packet-granular round-robin arbiter that merges the AXI-Stream outputs of NUM_PORTS MAC RX queues into one 64-bit AXI-Stream toward the input arbiter / DMA. It never interleaves packets: once a port is granted, it keeps the output until its tlast beat is accepted. It also keeps per-port saturating counters for forwarded packets and MAC-flagged bad frames (the err_tvalid pulses), readable by the register block.

Parameters:
NUM_PORTS, 4, number of RX queue inputs (2..8)
DATA_WIDTH, 64, tdata width; only 64 is supported
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  system clock; all logic in this domain
resetn  in  1  synchronous, active-low reset
s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data, port i at bits [i*64 +: 64]
s_tstrb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes
s_tvalid  in  NUM_PORTS  per-port valid
s_tlast  in  NUM_PORTS  per-port end of packet
s_tready  out  NUM_PORTS  per-port ready
s_err  in  NUM_PORTS  per-port one-cycle bad-frame pulse (err_tvalid)
m_tdata  out  DATA_WIDTH  merged data
m_tstrb  out  DATA_WIDTH/8  merged strobes
m_tvalid  out  1  merged valid
m_tlast  out  1  merged end of packet
m_tready  in  1  downstream ready
m_tport  out  log2(NUM_PORTS) (min 1)  source port of the current beat
clr_cnt  in  1  synchronous clear of all counters
pkt_cnt  out  NUM_PORTS*CNT_WIDTH  packets forwarded per port
err_cnt  out  NUM_PORTS*CNT_WIDTH  bad frames reported per port

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, grant=0, last_ptr=NUM_PORTS-1 so port 0 has first priority, all counters=0. While in reset and on the cycle after: m_tvalid=0, s_tready=0.
- State IDLE:
  - Rotating-priority search over s_tvalid, starting at last_ptr+1 and wrapping modulo NUM_PORTS.
  - If any port requests: register grant=winner and go to PASS.
  - No beat is transferred in IDLE, so each packet costs one bubble cycle.
- State PASS:
  - m_tdata, m_tstrb, m_tlast and m_tvalid are combinational muxes of the granted port's signals.
  - m_tport=grant.
  - s_tready[grant]=m_tready; every other s_tready bit is 0.
  - Zero-cycle datapath latency.
- Beat handshake: m_tvalid & m_tready.
- Handshake with m_tlast=1: last_ptr<=grant, state<=IDLE.
- Granted port drops tvalid mid-packet: stay in PASS with m_tvalid=0. No timeout and no regrant.
- m_tvalid=0 whenever state!=PASS. m_tdata and m_tstrb are don't-care when m_tvalid=0.
- A single requester is regranted on every packet, with one bubble cycle between packets.
- pkt_cnt[i]: increments on a handshake with m_tlast=1 while grant==i.
- err_cnt[i]: increments on s_err[i]=1, independent of the arbitration state.
- All counters saturate at all-ones with no wrap.
- clr_cnt=1 sets every counter to 0. It has priority over a same-cycle increment.
- s_err pulses on several ports in the same cycle: each err_cnt increments independently.
- Reset mid-packet: the grant is lost and the downstream sees a truncated packet. This is acceptable because the whole datapath resets together.
- Output ports are not registered. Any downstream timing register slice sits outside this block.

Decomposition:
- Shared package nf10_rx_pkg:
  - state encoding constants ST_IDLE=0, ST_PASS=1
  - AXI_DATA_WIDTH=64, STRB_WIDTH=8
  - clog2 helper function
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_PORTS], last_ptr.
  - Outputs: gnt_idx, gnt_valid.
  - Reusable by the TX-side scheduler.
- Counters stay inline using a generate loop.

Test Plan:
1. Reset, then port 2 sends a 3-beat packet (tstrb FF, FF, 0F), m_tready=1 -> grant=2 one cycle after s_tvalid rises; m_tport=2; 3 beats out unchanged with tlast on beat 3; pkt_cnt[2]=1; all other counters 0.
2. Ports 0..3 all hold a 2-beat packet valid continuously -> output order 0, 1, 2, 3, 0; no interleaving; exactly one bubble cycle between packets; pkt_cnt all 1 after the first four.
3. m_tready toggled 1,0,1,0 during port 1's 4-beat packet while port 3 is also valid -> port 1's beats stay contiguous; s_tready[3]=0 throughout; port 3 is granted only after port 1's tlast handshake.
4. Port 0 drops tvalid for 5 cycles mid-packet while port 1 is valid -> m_tvalid=0 for those cycles; the grant stays on port 0; port 1 starts after port 0's tlast.
5. s_err pulses on ports 1 and 3 in the same cycle, then clr_cnt pulses in the same cycle as a port-1 packet's tlast -> err_cnt[1]=err_cnt[3]=1 after the pulses; after the clear all counters=0, including pkt_cnt[1].
6. Force pkt_cnt[0] to 32'hFFFFFFFE, then send 3 packets on port 0 -> pkt_cnt[0] reaches 32'hFFFFFFFF and holds there.

Source files
------------

// File: rtl/nf10_rx_pkg.sv
// rtl/nf10_rx_pkg.sv - shared types and constants for the RX-side arbitration path
package nf10_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  localparam int AXI_DATA_WIDTH = 64;
  localparam int STRB_WIDTH     = 8;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker starting just after last_ptr
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_WIDTH-1:0] last_ptr,
  output logic [PTR_WIDTH-1:0] gnt_idx,
  output logic                 gnt_valid
);

  function automatic logic [PTR_WIDTH-1:0] wrap_idx(input logic [PTR_WIDTH-1:0] base, input int k);
    return PTR_WIDTH'((int'(base) + k) % NUM_PORTS);
  endfunction

  // Scan from the farthest slot to the nearest so the nearest requester overwrites.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req[wrap_idx(last_ptr, k)]) begin
        gnt_idx   = wrap_idx(last_ptr, k);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_queue_arbiter.sv
// rtl/rx_queue_arbiter.sv - packet-granular round-robin merge of RX queue streams with per-port stats
module rx_queue_arbiter
  import nf10_rx_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int CNT_WIDTH  = 32,
  localparam int PW        = clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0] s_tstrb,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS-1:0]            s_err,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [STRB_WIDTH-1:0]           m_tstrb,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [PW-1:0]                   m_tport,
  input  logic                            clr_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  err_cnt
);

  state_t        state, state_nxt;
  logic [PW-1:0] grant, last_ptr, pick_idx;
  logic          pick_valid, active, sel_valid, beat_last;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_WIDTH (PW)
  ) u_pick (
    .req       (s_tvalid),
    .last_ptr  (last_ptr),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // Gated by resetn so nothing is offered or accepted while reset is held.
  assign active    = resetn && (state == ST_PASS);
  assign m_tvalid  = active && sel_valid;
  assign m_tport   = grant;
  assign beat_last = m_tvalid && m_tready && m_tlast;

  always_comb begin
    m_tdata   = '0;
    m_tstrb   = '0;
    m_tlast   = 1'b0;
    sel_valid = 1'b0;
    s_tready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == PW'(i)) begin
        m_tdata     = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_tstrb     = s_tstrb[i*STRB_WIDTH +: STRB_WIDTH];
        m_tlast     = s_tlast[i];
        sel_valid   = s_tvalid[i];
        s_tready[i] = active && m_tready;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nxt = ST_PASS;
      ST_PASS: if (beat_last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      grant    <= '0;
      last_ptr <= PW'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_valid) grant <= pick_idx;
      if (beat_last) last_ptr <= grant;
    end
  end

  // Saturating statistics; clr_cnt wins over a same-cycle increment.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : gen_cnt
    logic [CNT_WIDTH-1:0] pkt_q, err_q;

    always_ff @(posedge clk) begin
      if (!resetn || clr_cnt) begin
        pkt_q <= '0;
        err_q <= '0;
      end else begin
        if (beat_last && grant == PW'(i) && pkt_q != '1) pkt_q <= pkt_q + 1'b1;
        if (s_err[i] && err_q != '1) err_q <= err_q + 1'b1;
      end
    end

    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = pkt_q;
    assign err_cnt[i*CNT_WIDTH +: CNT_WIDTH] = err_q;
  end

endmodule

// File: tb/tb_rx_queue_arbiter.sv
// tb/tb_rx_queue_arbiter.sv - scoreboard bench for rx_queue_arbiter
module tb_rx_queue_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int CW = 32;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*8-1:0]   s_tstrb;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tready, s_err;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tstrb;
  logic              m_tvalid, m_tlast, m_tready;
  logic [1:0]        m_tport;
  logic              clr_cnt;
  logic [NP*CW-1:0]  pkt_cnt, err_cnt;

  logic [127:0]      sm_s_tdata;
  logic [15:0]       sm_s_tstrb;
  logic [1:0]        sm_s_tvalid, sm_s_tlast, sm_s_tready, sm_s_err;
  logic [63:0]       sm_m_tdata;
  logic [7:0]        sm_m_tstrb;
  logic              sm_m_tvalid, sm_m_tlast, sm_m_tready;
  logic [0:0]        sm_m_tport;
  logic [3:0]        sm_pkt_cnt, sm_err_cnt;

  logic [63:0] p_data [NP];
  logic [7:0]  p_strb [NP];
  logic        p_valid[NP];
  logic        p_last [NP];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    pkt_port = -1;
  int    last_end = -1;
  int    mon_p;
  beat_t mon_e;
  beat_t exp_q[NP][$];
  int    got_order[$];
  int    gaps[$];
  bit    p1_done;

  rx_queue_arbiter dut (
    .clk(clk), .resetn(resetn),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_err(s_err),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .m_tport(m_tport),
    .clr_cnt(clr_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  rx_queue_arbiter #(.NUM_PORTS(2), .CNT_WIDTH(2)) dut_sm (
    .clk(clk), .resetn(resetn),
    .s_tdata(sm_s_tdata), .s_tstrb(sm_s_tstrb), .s_tvalid(sm_s_tvalid), .s_tlast(sm_s_tlast),
    .s_tready(sm_s_tready), .s_err(sm_s_err),
    .m_tdata(sm_m_tdata), .m_tstrb(sm_m_tstrb), .m_tvalid(sm_m_tvalid), .m_tlast(sm_m_tlast),
    .m_tready(sm_m_tready), .m_tport(sm_m_tport),
    .clr_cnt(clr_cnt), .pkt_cnt(sm_pkt_cnt), .err_cnt(sm_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < NP; i++) begin
      s_tdata[i*DW +: DW] = p_data[i];
      s_tstrb[i*8 +: 8]   = p_strb[i];
      s_tvalid[i]         = p_valid[i];
      s_tlast[i]          = p_last[i];
    end
  end

  always @(negedge clk) begin
    #3;
    if (resetn && m_tvalid && m_tready) begin
      mon_p = int'(m_tport);
      checks++;
      if (exp_q[mon_p].size() == 0) begin
        errors++;
        $display("FAIL sb_extra port=%0d got=%h expected=no beat", mon_p, m_tdata);
      end else begin
        mon_e = exp_q[mon_p].pop_front();
        if (m_tdata !== mon_e.d || m_tstrb !== mon_e.s || m_tlast !== mon_e.l) begin
          errors++;
          $display("FAIL sb_beat port=%0d got=%h/%h/%b expected=%h/%h/%b",
                   mon_p, m_tdata, m_tstrb, m_tlast, mon_e.d, mon_e.s, mon_e.l);
        end
      end
      if (pkt_port >= 0) begin
        checks++;
        if (mon_p != pkt_port) begin
          errors++;
          $display("FAIL interleave got_port=%0d expected_port=%0d", mon_p, pkt_port);
        end
      end else if (last_end >= 0) begin
        gaps.push_back(cyc - last_end);
      end
      if (m_tlast) begin
        got_order.push_back(mon_p);
        last_end = cyc;
        pkt_port = -1;
      end else begin
        pkt_port = mon_p;
      end
    end
  end

  function automatic logic [CW-1:0] pcnt(input int i);
    return pkt_cnt[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] ecnt(input int i);
    return err_cnt[i*CW +: CW];
  endfunction

  task automatic send_pkt(input int p, input int n, input logic [15:0] tag, input int gap_at, input int gap_len);
    beat_t e;
    int    w;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      e.d = {tag, 8'(p), 8'(b), $urandom};
      e.s = (b == n - 1) ? 8'h0F : 8'hFF;
      e.l = (b == n - 1);
      p_data[p] = e.d;
      p_strb[p] = e.s;
      p_last[p] = e.l;
      p_valid[p] = 1'b1;
      exp_q[p].push_back(e);
      #1;
      w = 0;
      while (!s_tready[p]) begin
        @(negedge clk);
        #1;
        w++;
        if (w > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout port=%0d beat=%0d waited=%0d required<=200", p, b, w);
          return;
        end
      end
      @(posedge clk);
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          p_valid[p] = 1'b0;
          #1;
          checks++;
          if (m_tvalid !== 1'b0 || m_tport !== 2'(p) || s_tready !== (4'b0001 << p)) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got valid=%b port=%0d ready=%b expected valid=0 port=%0d ready=%b",
                     g, m_tvalid, m_tport, s_tready, p, 4'b0001 << p);
          end
        end
      end
    end
  endtask

  task automatic port_off(input int p);
    @(negedge clk);
    p_valid[p] = 1'b0;
    p_last[p]  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pkt_port = -1;
  endtask

  task automatic check_drained(input string name);
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (exp_q[p].size() != 0) begin
        errors++;
        $display("FAIL %s_drained port=%0d got=%0d pending expected=0", name, p, exp_q[p].size());
      end
    end
  endtask

  task automatic check_order(input string name, input int exp_order[$]);
    checks++;
    if (got_order.size() != exp_order.size()) begin
      errors++;
      $display("FAIL %s_order_len got=%0d expected=%0d", name, got_order.size(), exp_order.size());
    end else begin
      foreach (exp_order[k]) begin
        checks++;
        if (got_order[k] != exp_order[k]) begin
          errors++;
          $display("FAIL %s_order idx=%0d got=%0d expected=%0d", name, k, got_order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    m_tready = 1'b1;
    p_valid[0] = 1'b1;
    p_last[0]  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b ready=%b expected valid=0 ready=0000", m_tvalid, s_tready);
    end
    checks++;
    if (pkt_cnt !== '0 || err_cnt !== '0 || sm_pkt_cnt !== '0 || sm_err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters got pkt=%h err=%h expected=0", pkt_cnt, err_cnt);
    end
    @(negedge clk);
    p_valid[0] = 1'b0;
    p_last[0]  = 1'b0;
    resetn     = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_after got valid=%b ready=%b expected valid=0 ready=0000", m_tvalid, s_tready);
    end
  endtask

  task automatic test_single_packet();
    fork
      begin
        send_pkt(2, 3, 16'h2222, -1, 0);
        port_off(2);
      end
      begin
        @(negedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL single_bubble got valid=%b expected=0", m_tvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tport !== 2'd2 || s_tready !== 4'b0100) begin
          errors++;
          $display("FAIL single_grant got valid=%b port=%0d ready=%b expected valid=1 port=2 ready=0100",
                   m_tvalid, m_tport, s_tready);
        end
      end
    join
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pcnt(i) !== ((i == 2) ? 32'd1 : 32'd0) || ecnt(i) !== 32'd0) begin
        errors++;
        $display("FAIL single_cnt port=%0d got pkt=%0d err=%0d expected pkt=%0d err=0", i, pcnt(i), ecnt(i), (i == 2));
      end
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    int exp_order[$] = '{0, 1, 2, 3, 0};
    do_reset();
    got_order.delete();
    gaps.delete();
    last_end = -1;
    fork
      begin
        send_pkt(0, 2, 16'h0A00, -1, 0);
        send_pkt(0, 2, 16'h0A01, -1, 0);
        port_off(0);
      end
      begin send_pkt(1, 2, 16'h1A00, -1, 0); port_off(1); end
      begin send_pkt(2, 2, 16'h2A00, -1, 0); port_off(2); end
      begin send_pkt(3, 2, 16'h3A00, -1, 0); port_off(3); end
    join
    @(negedge clk);
    #1;
    check_order("rr", exp_order);
    checks++;
    if (gaps.size() != 4) begin
      errors++;
      $display("FAIL rr_gap_count got=%0d expected=4", gaps.size());
    end
    foreach (gaps[k]) begin
      checks++;
      if (gaps[k] != 2) begin
        errors++;
        $display("FAIL rr_bubble idx=%0d got=%0d cycles expected=2", k, gaps[k]);
      end
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pcnt(i) !== ((i == 0) ? 32'd2 : 32'd1)) begin
        errors++;
        $display("FAIL rr_pkt_cnt port=%0d got=%0d expected=%0d", i, pcnt(i), (i == 0) ? 2 : 1);
      end
    end
    check_drained("rr");
  endtask

  task automatic test_backpressure();
    int exp_order[$] = '{1, 3};
    got_order.delete();
    p1_done = 1'b0;
    fork
      begin
        send_pkt(1, 4, 16'h1B1B, -1, 0);
        p1_done = 1'b1;
        port_off(1);
      end
      begin
        send_pkt(3, 2, 16'h3B3B, -1, 0);
        port_off(3);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          m_tready = (i % 2 == 0);
          #1;
          if (!p1_done) begin
            checks++;
            if (s_tready[3] !== 1'b0) begin
              errors++;
              $display("FAIL bp_ready3 cyc=%0d got=%b expected=0", i, s_tready[3]);
            end
          end
        end
        m_tready = 1'b1;
      end
    join
    @(negedge clk);
    #1;
    check_order("bp", exp_order);
    check_drained("bp");
  endtask

  task automatic test_stall();
    int exp_order[$] = '{0, 1};
    got_order.delete();
    fork
      begin send_pkt(0, 4, 16'h0C0C, 1, 5); port_off(0); end
      begin send_pkt(1, 2, 16'h1C1C, -1, 0); port_off(1); end
    join
    @(negedge clk);
    #1;
    check_order("stall", exp_order);
    check_drained("stall");
  endtask

  task automatic test_err_clear();
    int hit;
    @(negedge clk);
    s_err = 4'b1010;
    @(negedge clk);
    s_err = 4'b0000;
    #1;
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (ecnt(i) !== ((i == 1 || i == 3) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL err_cnt port=%0d got=%0d expected=%0d", i, ecnt(i), (i == 1 || i == 3));
      end
    end
    hit = 0;
    fork
      begin send_pkt(1, 2, 16'h1E1E, -1, 0); port_off(1); end
      begin
        for (int i = 0; i < 40 && hit == 0; i++) begin
          @(negedge clk);
          #2;
          if (s_tvalid[1] && s_tlast[1] && s_tready[1]) begin
            clr_cnt = 1'b1;
            hit = 1;
            @(negedge clk);
            clr_cnt = 1'b0;
          end
        end
      end
    join
    checks++;
    if (hit != 1) begin
      errors++;
      $display("FAIL clr_align got=%0d expected=1", hit);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pcnt(i) !== 32'd0 || ecnt(i) !== 32'd0) begin
        errors++;
        $display("FAIL clr_cnt port=%0d got pkt=%0d err=%0d expected 0/0", i, pcnt(i), ecnt(i));
      end
    end
    check_drained("clr");
  endtask

  task automatic test_saturation();
    int nhs, nerr;
    nhs  = 0;
    nerr = 0;
    @(negedge clk);
    sm_m_tready = 1'b1;
    sm_s_tlast  = 2'b01;
    sm_s_tvalid = 2'b01;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sm_s_err = (i < 6) ? 2'b10 : 2'b00;
      #1;
      checks++;
      if (sm_pkt_cnt[1:0] !== 2'((nhs > 3) ? 3 : nhs) || sm_err_cnt[3:2] !== 2'((nerr > 3) ? 3 : nerr)) begin
        errors++;
        $display("FAIL sat_cnt cyc=%0d got pkt=%0d err=%0d expected pkt=%0d err=%0d",
                 i, sm_pkt_cnt[1:0], sm_err_cnt[3:2], (nhs > 3) ? 3 : nhs, (nerr > 3) ? 3 : nerr);
      end
      if (sm_m_tvalid && sm_m_tready && sm_m_tlast) nhs++;
      if (sm_s_err[1]) nerr++;
    end
    sm_s_tvalid = 2'b00;
    sm_s_err    = 2'b00;
    checks++;
    if (sm_pkt_cnt !== 4'b0011 || sm_err_cnt !== 4'b1100) begin
      errors++;
      $display("FAIL sat_final got pkt=%b err=%b expected pkt=0011 err=1100", sm_pkt_cnt, sm_err_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      p_data[i]  = '0;
      p_strb[i]  = '0;
      p_valid[i] = 1'b0;
      p_last[i]  = 1'b0;
    end
    resetn      = 1'b0;
    m_tready    = 1'b1;
    s_err       = '0;
    clr_cnt     = 1'b0;
    sm_s_tdata  = '0;
    sm_s_tstrb  = '0;
    sm_s_tvalid = '0;
    sm_s_tlast  = '0;
    sm_s_err    = '0;
    sm_m_tready = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_err_clear();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
